// File: rtl/add_pkg.sv
// Shared definitions for the chunked adder sequencer: slice width, FSM
// state encoding and a constant log2 helper used to size the chunk counter.
package add_pkg;

  localparam int CHUNK_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/add5_slice.sv
// Purely combinational ripple-carry adder slice, CHUNK_W bits wide, built
// from per-bit full-adder equations.
module add5_slice
  import add_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s,
  output logic               co
);

  logic [CHUNK_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[CHUNK_W];
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide adder that reuses one CHUNK_W-bit slice, LSB chunk first, with
// valid/ready on both sides. Define ADD_SEQ_SUB_EN to add the sub port (X-Y).
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one chunk per cycle through the slice, carry chained via carry_q
// DONE  | result held on s/c_out with out_valid until out_ready
module add_seq_ctrl
  import add_pkg::*;
#(
  parameter  int NCHUNK = 4,
  localparam int W      = CHUNK_W * NCHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
`ifdef ADD_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         busy
);

  localparam int CW = clog2(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   x_sh_q, x_sh_d;
  logic [W-1:0]   y_sh_q, y_sh_d;
  logic [W-1:0]   s_q, s_d;
  logic           carry_q, carry_d;
  logic           c_out_q, c_out_d;
  logic           out_valid_q, out_valid_d;
  logic [CHUNK_W-1:0] slice_b;
  logic [CHUNK_W-1:0] slice_s;
  logic               slice_co;

`ifdef ADD_SEQ_SUB_EN
  logic sub_q, sub_d;
  // Subtraction is x + ~y + 1: invert each y chunk, seed carry with 1.
  assign slice_b = y_sh_q[CHUNK_W-1:0] ^ {CHUNK_W{sub_q}};
`else
  assign slice_b = y_sh_q[CHUNK_W-1:0];
`endif

  add5_slice u_slice (
    .a  (x_sh_q[CHUNK_W-1:0]),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_sh_d      = x_sh_q;
    y_sh_d      = y_sh_q;
    s_d         = s_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    sub_d       = sub_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_sh_d  = x;
          y_sh_d  = y;
          cnt_d   = '0;
          s_d     = '0;
          c_out_d = 1'b0;
`ifdef ADD_SEQ_SUB_EN
          sub_d   = sub;
          carry_d = sub;
`else
          carry_d = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        // Result chunks enter at the MSB end so chunk 0 lands at the bottom.
        s_d     = {slice_s, s_q[W-1:CHUNK_W]};
        x_sh_d  = {{CHUNK_W{1'b0}}, x_sh_q[W-1:CHUNK_W]};
        y_sh_d  = {{CHUNK_W{1'b0}}, y_sh_q[W-1:CHUNK_W]};
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          c_out_d     = slice_co;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_sh_q      <= '0;
      y_sh_q      <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_sh_q      <= x_sh_d;
      y_sh_q      <= y_sh_d;
      s_q         <= s_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
`ifdef ADD_SEQ_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign s         = s_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;

endmodule
